// File: rtl/tiny_alu_pkg.sv
// Shared types for the sequential tiny ALU: opcode encoding, FSM states, legality helper.
// Optional feature macro used by the design: TINY_ALU_SEQ_ERR_EN.
package tiny_alu_pkg;

  localparam int OPCODE_BITS = 3;

  typedef enum logic [OPCODE_BITS-1:0] {
    NOP_OP = 3'd0,
    ADD_OP = 3'd1,
    AND_OP = 3'd2,
    XOR_OP = 3'd3,
    MUL_OP = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Encodings above MUL_OP are reserved and treated as illegal requests.
  function automatic logic isLegalOp(input logic [OPCODE_BITS-1:0] op);
    return (op <= MUL_OP);
  endfunction

endpackage

// File: rtl/tiny_alu_seq_if.sv
// Request/response bundle of tiny_alu_seq; master drives requests, slave is the ALU.
// err_o only exists when TINY_ALU_SEQ_ERR_EN is defined.
interface tiny_alu_seq_if #(
  parameter int DATA_W = 8
);
  import tiny_alu_pkg::*;

  logic                   start_i;
  logic [OPCODE_BITS-1:0] opcode_i;
  logic [DATA_W-1:0]      a_i;
  logic [DATA_W-1:0]      b_i;
  logic                   ready_o;
  logic                   done_o;
  logic [2*DATA_W-1:0]    result_o;
`ifdef TINY_ALU_SEQ_ERR_EN
  logic                   err_o;

  modport master (
    output start_i, opcode_i, a_i, b_i,
    input  ready_o, done_o, result_o, err_o
  );

  modport slave (
    input  start_i, opcode_i, a_i, b_i,
    output ready_o, done_o, result_o, err_o
  );
`else
  modport master (
    output start_i, opcode_i, a_i, b_i,
    input  ready_o, done_o, result_o
  );

  modport slave (
    input  start_i, opcode_i, a_i, b_i,
    output ready_o, done_o, result_o
  );
`endif

endinterface

// File: rtl/tiny_alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one iteration per cycle, exactly DATA_W cycles.
// The accumulator holds {partial upper half, remaining multiplier bits}.
module tiny_alu_seq_mul #(
  parameter int DATA_W = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                load_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                busy_o,
  output logic                last_o,
  output logic [2*DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_mcand;
  logic [2*DATA_W-1:0] r_acc;
  logic                r_busy;
  logic [DATA_W:0]     w_sum;

  // Carry out of the upper-half add shifts into the MSB on the same step.
  assign w_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
               + {1'b0, ({DATA_W{r_acc[0]}} & r_mcand)};

  assign busy_o    = r_busy;
  assign last_o    = (r_cnt == CNT_W'(DATA_W - 1));
  assign product_o = r_acc;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
    end else if (load_i) begin
      r_cnt   <= '0;
      r_mcand <= a_i;
      r_acc   <= {{DATA_W{1'b0}}, b_i};
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_acc <= {w_sum, r_acc[DATA_W-1:1]};
      r_cnt <= r_cnt + 1'b1;
      if (last_o) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tiny_alu_seq.sv
// Sequential tiny ALU: single-cycle ADD/AND/XOR/NOP, DATA_W-cycle MUL, ready/start/done handshake.
// Define TINY_ALU_SEQ_ERR_EN to get err_o pulses for illegal opcodes and starts while busy.
module tiny_alu_seq
  import tiny_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  tiny_alu_seq_if.slave   bus
);

  state_t              r_state;
  state_t              w_nextState;
  logic                w_accept;
  logic                w_legal;
  logic                w_isMul;
  logic                w_mulLoad;
  logic                w_mulBusy;
  logic                w_mulLast;
  logic [2*DATA_W-1:0] w_product;
  logic [DATA_W:0]     w_addSum;
  logic [2*DATA_W-1:0] w_singleRes;
  logic [2*DATA_W-1:0] r_result;
  logic                r_mulPending;

  assign bus.ready_o = (r_state != ST_MUL);
  assign bus.done_o  = (r_state == ST_DONE);
  assign w_accept    = bus.start_i && bus.ready_o;
  assign w_legal     = isLegalOp(bus.opcode_i);
  assign w_isMul     = (bus.opcode_i == MUL_OP);
  assign w_mulLoad   = w_accept && w_isMul;

  // A finished MUL is shown straight from the multiplier during DONE and committed on leaving it.
  assign bus.result_o = (r_state == ST_DONE && r_mulPending) ? w_product : r_result;

  tiny_alu_seq_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (w_mulLoad),
    .a_i       (bus.a_i),
    .b_i       (bus.b_i),
    .busy_o    (w_mulBusy),
    .last_o    (w_mulLast),
    .product_o (w_product)
  );

  assign w_addSum = {1'b0, bus.a_i} + {1'b0, bus.b_i};

  always_comb begin
    w_singleRes = '0;
    case (bus.opcode_i)
      ADD_OP:  w_singleRes = {{(DATA_W-1){1'b0}}, w_addSum};
      AND_OP:  w_singleRes = {{DATA_W{1'b0}}, bus.a_i & bus.b_i};
      XOR_OP:  w_singleRes = {{DATA_W{1'b0}}, bus.a_i ^ bus.b_i};
      default: w_singleRes = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept && w_isMul) begin
          w_nextState = ST_MUL;
        end else if (w_accept && w_legal) begin
          w_nextState = ST_DONE;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_mulBusy && w_mulLast) begin
          w_nextState = ST_DONE;
        end else begin
          w_nextState = ST_MUL;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Later assignments take priority: a new single-cycle op in DONE overwrites the committed product.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_result     <= '0;
      r_mulPending <= 1'b0;
    end else begin
      if (r_state == ST_DONE && r_mulPending) begin
        r_result     <= w_product;
        r_mulPending <= 1'b0;
      end
      if (w_accept && w_legal && !w_isMul) begin
        r_result <= w_singleRes;
      end
      if (w_mulLoad) begin
        r_mulPending <= 1'b1;
      end
    end
  end

`ifdef TINY_ALU_SEQ_ERR_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_accept && !w_legal) || (bus.start_i && !bus.ready_o);
    end
  end

  assign bus.err_o = r_err;
`endif

endmodule

// File: tb/tb_tiny_alu_seq.sv
// Scoreboard bench for tiny_alu_seq: directed scenarios plus randomized traffic against an arithmetic model.
// Checks err_o as well when TINY_ALU_SEQ_ERR_EN is defined.
module tb_tiny_alu_seq;

  localparam int DATA_W = 8;
  localparam int RW     = 2 * DATA_W;

  typedef struct {
    logic [RW-1:0] res;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   errors;

  exp_t          sb[$];
  logic [RW-1:0] lastRes;
  int            busyStart;
  int            busyEnd;
  bit            errAt[int];

  tiny_alu_seq_if #(.DATA_W(DATA_W)) bus ();

  tiny_alu_seq #(.DATA_W(DATA_W)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [RW-1:0] refResult(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [RW-1:0] ea;
    logic [RW-1:0] eb;
    ea = RW'(a);
    eb = RW'(b);
    case (op)
      3'd1:    return ea + eb;
      3'd2:    return ea & eb;
      3'd3:    return ea ^ eb;
      3'd4:    return ea * eb;
      default: return '0;
    endcase
  endfunction

  function automatic bit modelBusy(input int k);
    return (k >= busyStart) && (k <= busyEnd);
  endfunction

  // Called at a falling edge; the request is sampled on the following rising edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int k;
    k = cyc;
    bus.start_i  = 1'b1;
    bus.opcode_i = op;
    bus.a_i      = a;
    bus.b_i      = b;
    if (modelBusy(k)) begin
      errAt[k+1] = 1'b1;
    end else if (op > 3'd4) begin
      errAt[k+1] = 1'b1;
    end else if (op == 3'd4) begin
      sb.push_back('{refResult(op, a, b), k + DATA_W + 1});
      busyStart = k + 1;
      busyEnd   = k + DATA_W;
    end else begin
      sb.push_back('{refResult(op, a, b), k + 1});
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clearModel();
    sb.delete();
    errAt.delete();
    busyStart = 1;
    busyEnd   = 0;
    lastRes   = '0;
  endtask

  // Monitor: ready/hold/result/latency (and err) every cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      checkOutput("ready", 64'(bus.ready_o), 64'(!modelBusy(cyc)));
      if (bus.done_o) begin
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done_o=1 result 0x%0h, expected no done (cycle %0d)",
                   bus.result_o, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("result", 64'(bus.result_o), 64'(e.res));
          checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
          lastRes = e.res;
        end
      end else begin
        checkOutput("hold", 64'(bus.result_o), 64'(lastRes));
      end
`ifdef TINY_ALU_SEQ_ERR_EN
      checkOutput("err", 64'(bus.err_o), 64'(errAt.exists(cyc)));
`endif
    end
  end

  initial begin
    int waitCnt;
    vectors = 0;
    errors  = 0;
    clearModel();
    bus.start_i  = 1'b0;
    bus.opcode_i = '0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    rst_n        = 1'b0;
    #1;
    checkOutput("reset_ready", 64'(bus.ready_o), 64'd1);
    checkOutput("reset_done", 64'(bus.done_o), 64'd0);
    checkOutput("reset_result", 64'(bus.result_o), 64'd0);
    idleCycles(2);
    #2 rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] directed scenarios");
    applyStimulus(3'd1, 8'hFF, 8'h01);
    idleCycles(2);
    applyStimulus(3'd4, 8'hFF, 8'hFF);
    idleCycles(10);
    applyStimulus(3'd2, 8'hF0, 8'h3C);
    applyStimulus(3'd3, 8'hAA, 8'hFF);
    idleCycles(2);
    applyStimulus(3'd4, 8'h03, 8'h05);
    idleCycles(2);
    applyStimulus(3'd1, 8'h11, 8'h22);
    idleCycles(8);
    applyStimulus(3'd7, 8'h12, 8'h34);
    idleCycles(2);
    applyStimulus(3'd0, 8'h55, 8'h66);
    applyStimulus(3'd4, 8'h00, 8'hC3);
    idleCycles(10);
    applyStimulus(3'd4, 8'h81, 8'h00);
    applyStimulus(3'd1, 8'h80, 8'h80);
    idleCycles(10);

    $display("[TB] reset during MUL");
    applyStimulus(3'd4, 8'h9D, 8'h47);
    idleCycles(3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 64'(bus.ready_o), 64'd1);
    checkOutput("abort_done", 64'(bus.done_o), 64'd0);
    checkOutput("abort_result", 64'(bus.result_o), 64'd0);
    clearModel();
    @(negedge clk);
    #2 rst_n = 1'b1;
    idleCycles(DATA_W + 4);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      logic [2:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(5, 7));
      else                           op = 3'($urandom_range(0, 4));
      a = DATA_W'($urandom);
      b = DATA_W'($urandom);
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '0;
      applyStimulus(op, a, b);
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end

    waitCnt = 0;
    while (sb.size() != 0 && waitCnt < 4 * DATA_W + 10) begin
      @(negedge clk);
      waitCnt++;
    end
    if (sb.size() != 0) begin
      vectors++;
      errors++;
      $display("[TB] FAIL drain: got %0d outstanding results, expected 0", sb.size());
    end
    idleCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
